// File: rtl/ps2_rx_frontend.sv
// PS/2 device-to-host receiver: pin synchronisers, clock de-glitch filter, 11-bit frame FSM, show-ahead byte FIFO.
// Optional macro PS2_RX_TIMEOUT_EN adds an in-frame idle timeout that aborts with frame_err.
`timescale 1ns/1ps
module ps2_rx_frontend #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned BCW = 4;

  if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      FILTER_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_rx_frontend: illegal parameter value");
  end

  typedef enum logic {IDLE, RECV} state_t;

  // Pin synchronisers, preset to the idle-high bus level
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_s;
  logic                   data_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // Glitch filter: follow the synchronised clock only after FILTER_LEN differing samples in a row
  logic           filt_q, filt_d;
  logic           filt_prev_q;
  logic [FCW-1:0] flt_cnt_q, flt_cnt_d;
  logic           fall_c;

  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_s != filt_q) begin
      if (flt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        flt_cnt_d = flt_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      flt_cnt_q   <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      flt_cnt_q   <= flt_cnt_d;
    end
  end

  assign fall_c = filt_prev_q & ~filt_q;

  // FIFO status, needed by the frame FSM for the overflow decision
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          empty_c, full_c, pop_c, push_c;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
  assign pop_c   = rd_en && !empty_c;

  // Frame FSM: shift_q holds bits 1..9, so [7:0] is the byte and [8] the parity bit
  state_t         state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [8:0]     shift_q, shift_d;
  logic           par_err_q, par_err_d;
  logic           frm_err_q, frm_err_d;
  logic           ovf_q, ovf_d;
  logic           timeout_c;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    if (!fall_c && state_q == RECV) begin
      to_cnt_d = to_cnt_q + TOW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_c = (state_q == RECV) && !fall_c && (to_cnt_q == TOW'(TIMEOUT_CYCLES));
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_c    = 1'b0;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    ovf_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_c && !data_s) begin
          bit_cnt_d = BCW'(1);
          state_d   = RECV;
        end
      end
      RECV: begin
        if (timeout_c) begin
          state_d   = IDLE;
          frm_err_d = 1'b1;
        end else if (fall_c) begin
          if (bit_cnt_q == BCW'(10)) begin
            state_d = IDLE;
            if (!data_s) begin
              frm_err_d = 1'b1;
            end else if (!(^shift_q)) begin
              par_err_d = 1'b1;
            end else if (full_c && !pop_c) begin
              ovf_d = 1'b1;
            end else begin
              push_c = 1'b1;
            end
          end else begin
            shift_d   = {data_s, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= ovf_d;
    end
  end

  // Byte storage needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign valid      = !empty_c;
  assign data       = empty_c ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign busy       = (state_q == RECV);
  assign parity_err = par_err_q;
  assign frame_err  = frm_err_q;
  assign overflow   = ovf_q;

endmodule
